// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the N-to-1 stream multiplexer and its
// round-robin arbiter.
//   mode_e   : channel selection mode (explicit key or round-robin)
//   wrap_inc : index increment with wrap-around at a given modulus
// ---------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic {
    MUX_MODE_KEY = 1'b0,
    MUX_MODE_RR  = 1'b1
  } mode_e;

  // Next index after idx, wrapping back to 0 once n is reached.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over CHAN_NUM requesters. The search for a grant
// starts one past the last winner (r_ptr) and wraps, so r_ptr itself is
// considered last. r_ptr only moves when the owner strobes i_en, which lets
// the caller decide what counts as a completed grant.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst     : asynchronous active-high reset (r_ptr -> CHAN_NUM-1)
//   i_req     : per-channel request
//   i_en      : commit the current grant into r_ptr
//   o_gnt_idx : granted channel index (0 when nothing is granted)
//   o_gnt_vld : a grant exists this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHAN_NUM  = 4,
  localparam int KEY_WIDTH = $clog2(CHAN_NUM)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CHAN_NUM-1:0]  i_req,
  input  logic                 i_en,
  output logic [KEY_WIDTH-1:0] o_gnt_idx,
  output logic                 o_gnt_vld
);

  logic [KEY_WIDTH-1:0] r_ptr;
  logic [KEY_WIDTH-1:0] cand;
  int unsigned          idx;

  // Reset to the last channel so the very first search begins at channel 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= KEY_WIDTH'(CHAN_NUM - 1);
    end else if (i_en && o_gnt_vld) begin
      r_ptr <= o_gnt_idx;
    end
  end

  // Walk r_ptr+1, r_ptr+2, ... r_ptr and keep the first requester found.
  always_comb begin
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    idx       = 32'(r_ptr);
    cand      = '0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      idx  = wrap_inc(idx, CHAN_NUM);
      cand = KEY_WIDTH'(idx);
      if (!o_gnt_vld && i_req[cand]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// ---------------------------------------------------------------------------
// mux_n_1_stream
// N-to-1 valid/ready stream multiplexer with one output register stage.
// Selection is either by explicit key or by fair round-robin arbitration.
// The output register reloads whenever it is empty or being drained, so a
// steady stream moves one word per cycle with no bubbles.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_mode  : MUX_MODE_KEY (select by i_key) or MUX_MODE_RR (round-robin)
//   i_key   : channel select in key mode
//   i_valid : per-channel valid
//   o_ready : per-channel ready, one-hot or zero
//   i_val   : packed per-channel data
//   o_valid : output valid
//   i_ready : downstream ready
//   o_val   : output data
//   o_key   : source channel of o_val
// ---------------------------------------------------------------------------
module mux_n_1_stream
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int CHAN_NUM   = 4,
  localparam int KEY_WIDTH  = $clog2(CHAN_NUM)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  mode_e                               i_mode,
  input  logic [KEY_WIDTH-1:0]                i_key,
  input  logic [CHAN_NUM-1:0]                 i_valid,
  output logic [CHAN_NUM-1:0]                 o_ready,
  input  logic [CHAN_NUM-1:0][DATA_WIDTH-1:0] i_val,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [DATA_WIDTH-1:0]               o_val,
  output logic [KEY_WIDTH-1:0]                o_key
);

  localparam int KEY_SPAN = 1 << KEY_WIDTH;

  logic                  load;
  logic                  key_in_range;
  logic                  key_vld;
  logic [KEY_SPAN-1:0]   valid_ext;
  logic [KEY_WIDTH-1:0]  rr_idx;
  logic                  rr_vld;
  logic [KEY_WIDTH-1:0]  gnt;
  logic                  gnt_vld;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  // Keys only fall out of range when CHAN_NUM is not a power of two.
  generate
    if (KEY_SPAN == CHAN_NUM) begin : g_full_key
      assign key_in_range = 1'b1;
    end else begin : g_part_key
      assign key_in_range = (32'(i_key) < CHAN_NUM);
    end
  endgenerate

  // Padding the valid vector keeps the key lookup in range for any key.
  assign valid_ext = KEY_SPAN'(i_valid);
  assign key_vld   = key_in_range && valid_ext[i_key];

  rr_arbiter #(
    .CHAN_NUM (CHAN_NUM)
  ) u_rr_arbiter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_valid),
    .i_en      (xfer && (i_mode == MUX_MODE_RR)),
    .o_gnt_idx (rr_idx),
    .o_gnt_vld (rr_vld)
  );

  assign load    = !o_valid || i_ready;
  assign gnt     = (i_mode == MUX_MODE_RR) ? rr_idx : i_key;
  assign gnt_vld = (i_mode == MUX_MODE_RR) ? rr_vld : key_vld;
  assign xfer    = load && gnt_vld;

  // A valid grant already implies i_valid[gnt], so ready alone marks the transfer.
  always_comb begin
    o_ready  = '0;
    sel_data = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (gnt == KEY_WIDTH'(c)) begin
        o_ready[c] = xfer;
        sel_data   = i_val[c];
      end
    end
  end

  // Output stage: data and key only change on an input transfer, so they
  // stay stable through a stall and hold their last values after a drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_val   <= '0;
      o_key   <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_val   <= sel_data;
      o_key   <= gnt;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
